// File: rtl/upsample2x.sv
// 2x nearest-neighbour upsampler for packed int8 vectors (row buffer + 2-entry output FIFO).
// Optional combinational passthrough via `scale_1`, enabled by UPSAMPLE_PASSTHRU_EN.
module upsample2x #(
  parameter int MAX_ROW_VEC = 4096,
  parameter int ADDR_W      = $clog2(MAX_ROW_VEC)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] img_width,
  input  logic [15:0] channels,
  input  logic [63:0] data_in,
  input  logic        valid_in,
  output logic        ready_in,
  output logic [63:0] data_out,
  output logic        valid_out,
  input  logic        ready_out,
  output logic        busy
`ifdef UPSAMPLE_PASSTHRU_EN
  ,
  input  logic        scale_1
`endif
);

  typedef enum logic {LOAD, EMIT} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       col_q, col_d;
  logic [15:0]       ch_q, ch_d;
  logic              rep_q, rep_d;
  logic              pass_q, pass_d;
  logic              all_q, all_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              rptr_q, wptr_q;
  logic [63:0]       fifo_q [2];
  logic [63:0]       mem [MAX_ROW_VEC];

  logic [15:0] c_w;
  logic        pt;
  logic        rdy_int;
  logic        acc;
  logic        pop;
  logic        issue;
  logic        ch_last;
  logic        col_last;

`ifdef UPSAMPLE_PASSTHRU_EN
  assign pt = scale_1;
`else
  assign pt = 1'b0;
`endif

  assign c_w      = channels >> 3;
  assign ch_last  = (ch_q == c_w - 16'd1);
  assign col_last = (col_q == img_width - 16'd1);
  assign rd_addr  = base_q + ADDR_W'(ch_q);

  assign rdy_int = (state_q == LOAD) && !rst && !pt;
  assign acc     = valid_in && rdy_int;
  assign pop     = (cnt_q != 2'd0) && ready_out && !rst;
  // Synchronous read lands straight in the FIFO, so a slot freed by
  // this cycle's delivery can be refilled in the same cycle.
  assign issue   = (state_q == EMIT) && !all_q && !rst
                && ((cnt_q < 2'd2) || pop);

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    base_d    = base_q;
    col_d     = col_q;
    ch_d      = ch_q;
    rep_d     = rep_q;
    pass_d    = pass_q;
    all_d     = all_q;
    cnt_d     = cnt_q + {1'b0, issue} - {1'b0, pop};
    unique case (state_q)
      LOAD: begin
        if (acc) begin
          wr_addr_d = wr_addr_q + 1'b1;
          if (ch_last) begin
            ch_d = '0;
            if (col_last) begin
              col_d     = '0;
              wr_addr_d = '0;
              state_d   = EMIT;
            end else begin
              col_d = col_q + 16'd1;
            end
          end else begin
            ch_d = ch_q + 16'd1;
          end
        end
      end
      EMIT: begin
        if (issue) begin
          if (ch_last) begin
            ch_d  = '0;
            rep_d = ~rep_q;
            if (rep_q) begin
              if (col_last) begin
                col_d  = '0;
                base_d = '0;
                pass_d = ~pass_q;
                if (pass_q) all_d = 1'b1;
              end else begin
                col_d  = col_q + 16'd1;
                base_d = base_q + ADDR_W'(c_w);
              end
            end
          end else begin
            ch_d = ch_q + 16'd1;
          end
        end
        if (all_q && cnt_d == 2'd0) begin
          all_d   = 1'b0;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD;
      wr_addr_q <= '0;
      base_q    <= '0;
      col_q     <= '0;
      ch_q      <= '0;
      rep_q     <= 1'b0;
      pass_q    <= 1'b0;
      all_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      base_q    <= base_d;
      col_q     <= col_d;
      ch_q      <= ch_d;
      rep_q     <= rep_d;
      pass_q    <= pass_d;
      all_q     <= all_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) mem[wr_addr_q] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q    <= 1'b0;
      wptr_q    <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      if (issue) begin
        fifo_q[wptr_q] <= mem[rd_addr];
        wptr_q         <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
    end
  end

  assign ready_in  = pt ? ready_out : rdy_int;
  assign valid_out = pt ? valid_in : ((cnt_q != 2'd0) && !rst);
  assign data_out  = pt ? data_in : (rst ? 64'd0 : fifo_q[rptr_q]);
  assign busy      = (state_q == EMIT) && !rst;

endmodule

// File: tb/tb_upsample2x.sv
// Directed testbench for upsample2x: replication order, latency, stalls, reset.
// Passthrough scenario is compiled only with UPSAMPLE_PASSTHRU_EN.
module tb_upsample2x;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] img_width;
  logic [15:0] channels;
  logic [63:0] data_in;
  logic        valid_in;
  logic        ready_in;
  logic [63:0] data_out;
  logic        valid_out;
  logic        ready_out;
  logic        busy;
`ifdef UPSAMPLE_PASSTHRU_EN
  logic        scale_1;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] row_q [$];
  logic [63:0] exp_q [$];

  upsample2x dut (
    .clk       (clk),
    .rst       (rst),
    .img_width (img_width),
    .channels  (channels),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .busy      (busy)
`ifdef UPSAMPLE_PASSTHRU_EN
    ,
    .scale_1   (scale_1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] w, input logic [15:0] ch);
    rst       = 1'b1;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    img_width = w;
    channels  = ch;
    #1;
    chk("rst valid_out", 64'(valid_out), 64'd0);
    chk("rst ready_in", 64'(ready_in), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic send_row(input bit keep);
    int g;
    foreach (row_q[i]) begin
      valid_in = 1'b1;
      data_in  = row_q[i];
      g = 0;
      while (!ready_in && g < 300) begin
        tick();
        g++;
      end
      if (!ready_in) chk("send timeout", 64'(g), 64'd0);
      tick();
    end
    if (!keep) valid_in = 1'b0;
  endtask

  task automatic collect(input int n, input bit rnd, input string tag,
                         output int cyc);
    int idx;
    bit stall;
    logic [63:0] held;
    idx   = 0;
    stall = 1'b0;
    held  = '0;
    cyc   = 0;
    while (idx < n && cyc < 300) begin
      ready_out = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stall) begin
        chk({tag, " hold valid"}, 64'(valid_out), 64'd1);
        chk({tag, " hold data"}, data_out, held);
      end
      if (valid_out && ready_out) begin
        chk(tag, data_out, exp_q[idx]);
        idx++;
      end
      stall = valid_out && !ready_out;
      held  = data_out;
      tick();
      cyc++;
    end
    if (idx < n) chk({tag, " timeout"}, 64'(idx), 64'(n));
    ready_out = 1'b1;
  endtask

  localparam logic [63:0] A  = 64'h0102_0304_0506_0708;
  localparam logic [63:0] B  = 64'h8182_8384_8586_8788;
  localparam logic [63:0] X0 = 64'hDEAD_BEEF_0000_1111;
  localparam logic [63:0] X1 = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] P0 = 64'hAAAA_0000_AAAA_0000;
  localparam logic [63:0] P1 = 64'h5555_0000_5555_0000;
  localparam logic [63:0] Q0 = 64'h0000_CCCC_0000_CCCC;
  localparam logic [63:0] Q1 = 64'h0000_3333_0000_3333;
  localparam logic [63:0] CC = 64'hC0C0_C0C0_C0C0_C0C0;
  localparam logic [63:0] DD = 64'hD0D0_D0D0_D0D0_D0D0;

  initial begin
    int cyc;
    logic [63:0] v [6];
    rst = 1'b1; valid_in = 1'b0; ready_out = 1'b1;
    data_in = '0; img_width = 16'd2; channels = 16'd8;
`ifdef UPSAMPLE_PASSTHRU_EN
    scale_1 = 1'b0;
`endif

    // 1: W=2, C=1, latency and order
    do_reset(16'd2, 16'd8);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset valid_out", 64'(valid_out), 64'd0);
    chk("reset ready_in", 64'(ready_in), 64'd1);
    row_q = '{A, B};
    send_row(1'b0);
    chk("t1 T+1 busy", 64'(busy), 64'd1);
    chk("t1 T+1 ready_in", 64'(ready_in), 64'd0);
    chk("t1 T+1 valid_out", 64'(valid_out), 64'd0);
    tick();
    chk("t1 T+2 valid_out", 64'(valid_out), 64'd1);
    exp_q = '{A, A, B, B, A, A, B, B};
    collect(8, 1'b0, "t1 out", cyc);
    chk("t1 cycles", 64'(cyc), 64'd8);
    chk("t1 T+10 ready_in", 64'(ready_in), 64'd1);
    chk("t1 T+10 valid_out", 64'(valid_out), 64'd0);
    chk("t1 T+10 busy", 64'(busy), 64'd0);

    // 2: W=1, channels=16
    do_reset(16'd1, 16'd16);
    row_q = '{X0, X1};
    send_row(1'b0);
    tick();
    exp_q = '{X0, X1, X0, X1, X0, X1, X0, X1};
    collect(8, 1'b0, "t2 out", cyc);
    chk("t2 cycles", 64'(cyc), 64'd8);

    // 3: W=3, C=2, random backpressure
    do_reset(16'd3, 16'd16);
    for (int i = 0; i < 6; i++)
      v[i] = {8'(i), 8'hF0, 8'(i * 3), 8'h80, 8'(255 - i), 8'h7F, 8'(i * 7), 8'h01};
    row_q = '{v[0], v[1], v[2], v[3], v[4], v[5]};
    send_row(1'b0);
    exp_q = '{};
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 2; r++) begin
          exp_q.push_back(v[2 * c]);
          exp_q.push_back(v[2 * c + 1]);
        end
    collect(24, 1'b1, "t3 out", cyc);
    chk("t3 back to load", 64'(busy), 64'd0);

    // 4: back-to-back rows, valid_in held high
    do_reset(16'd2, 16'd8);
    row_q = '{P0, P1};
    send_row(1'b1);
    data_in = Q0;
    chk("t4 no accept in emit", 64'(ready_in), 64'd0);
    exp_q = '{P0, P0, P1, P1, P0, P0, P1, P1};
    collect(8, 1'b0, "t4 P out", cyc);
    chk("t4 load resumed", 64'(ready_in), 64'd1);
    row_q = '{Q0, Q1};
    send_row(1'b0);
    exp_q = '{Q0, Q0, Q1, Q1, Q0, Q0, Q1, Q1};
    collect(8, 1'b0, "t4 Q out", cyc);

    // 5: reset mid-emit
    do_reset(16'd2, 16'd8);
    row_q = '{A, B};
    send_row(1'b0);
    tick();
    exp_q = '{A, A, B};
    collect(3, 1'b0, "t5 pre", cyc);
    rst = 1'b1;
    #1;
    chk("t5 rst valid_out", 64'(valid_out), 64'd0);
    chk("t5 rst data_out", data_out, 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5 post valid_out", 64'(valid_out), 64'd0);
    chk("t5 post ready_in", 64'(ready_in), 64'd1);
    chk("t5 post busy", 64'(busy), 64'd0);
    row_q = '{CC, DD};
    send_row(1'b0);
    exp_q = '{CC, CC, DD, DD, CC, CC, DD, DD};
    collect(8, 1'b0, "t5 out", cyc);

`ifdef UPSAMPLE_PASSTHRU_EN
    // 6: passthrough
    do_reset(16'd2, 16'd8);
    scale_1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      valid_in  = 1'b1;
      data_in   = 64'h1111_1111_1111_1111 * 64'(i + 1);
      ready_out = 1'(i % 2);
      #1;
      chk("t6 valid_out", 64'(valid_out), 64'd1);
      chk("t6 data_out", data_out, 64'h1111_1111_1111_1111 * 64'(i + 1));
      chk("t6 ready_in", 64'(ready_in), 64'(i % 2));
      chk("t6 busy", 64'(busy), 64'd0);
      tick();
    end
    valid_in  = 1'b0;
    ready_out = 1'b1;
    scale_1   = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/upsample2x.md
# upsample2x

2x nearest-neighbour upsampler for the packed int8 activation stream: 64-bit vectors, 8 channels per vector, pixel-major, channel-vector-minor. Every input pixel is replicated to a 2x2 output block, doubling width and height. It is the expanding counterpart of the 2x2 max-pool stage and sits in front of the route/concat path of the YOLO head. Output produces four vectors per input vector, so both sides use valid/ready handshakes.

## Interface

- `MAX_ROW_VEC`, 4096: row buffer depth in 64-bit vectors. Must be at least `img_width*(channels>>3)`.
- `ADDR_W`, `$clog2(MAX_ROW_VEC)`: buffer address width.

Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.

- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `img_width` in 16: input pixels per row. Valid range is 1 or more.
- `channels` in 16: channel count, a multiple of 8. `C = channels>>3` is 1 or more.
- `data_in` in 64: input vector, 8 signed int8 lanes.
- `valid_in` in 1: input vector valid.
- `ready_in` out 1: block accepts `data_in` this cycle.
- `data_out` out 64: output vector.
- `valid_out` out 1: `data_out` valid.
- `ready_out` in 1: downstream accepts this cycle.
- `busy` out 1: high in EMIT state.
- `scale_1` in 1: passthrough select. This port exists only with `UPSAMPLE_PASSTHRU_EN`.

## Operation

Definitions:
- `W = img_width`, `C = channels>>3`, `R = W*C` (vectors per input row).
- `img_width` and `channels` must be stable from reset release for the whole frame. Changing them needs `rst`.
- A vector is accepted when `valid_in && ready_in`.
- A vector is delivered when `valid_out && ready_out`.

Row buffer: single-port-write / single-port-read RAM of `MAX_ROW_VEC` x 64. Read latency is 1 cycle.

Output FIFO: 2-entry skid FIFO feeding `data_out`. `data_out` is the FIFO head.

State machine, LOAD and EMIT. Reset state is LOAD.

LOAD:
- `ready_in = 1`.
- Each accept writes `buf[wr_addr] <= data_in`, then `wr_addr++`.
- The accept at `wr_addr == R-1` clears `wr_addr` and moves to EMIT on the next cycle.
- No reads issue in LOAD.

EMIT:
- `ready_in = 0`.
- The read generator walks nested counters, outermost first:
  - `pass` 0..1
  - `col` 0..W-1
  - `rep` 0..1
  - `ch` 0..C-1
- Read address is `col*C + ch`. Keep a running base register; no multiplier.
- A read issues in a cycle when `fifo_count + inflight < 2`, counting the current cycle's delivery as freeing a slot.
- Read data enters the FIFO one cycle after issue.
- When all `4R` reads are issued, the FIFO is empty and no read is inflight, the state returns to LOAD on the next cycle.

Arithmetic and behaviour rules:
- The block performs no arithmetic on data; lanes pass bit-exact.
- Counters are 16-bit. `wr_addr` and `rd_addr` are `ADDR_W` wide.
- `R > MAX_ROW_VEC`, `C == 0` or `W == 0`: behaviour is undefined and not checked.
- Rows are independent. The block counts no frame height; every input row yields exactly two output rows of `2W` pixels.

Reset:
- Takes effect the cycle `rst` is high.
- State becomes LOAD. All counters clear. FIFO empties.
- `valid_out = 0`, `ready_in = 0` while `rst` is high, `busy = 0`, `data_out = 0`.
- Buffer contents are not cleared.
- Reset mid-EMIT discards the remaining outputs.

## Timing

Latency:
- Last accept of a row happens at cycle T. EMIT starts at T+1, first read issues at T+1, and `valid_out` first rises at T+2.
- With `ready_out` held high, one vector is delivered every cycle. The `4R` outputs span T+2 .. T+4R+1.
- LOAD resumes at T+4R+2, when `ready_in` returns to 1.

Stall rules:
- While `valid_out && !ready_out`, `data_out` holds stable.
- `valid_out` never deasserts without a delivery.
- No vector is dropped or duplicated beyond the specified replication.

Edge cases:
- `ready_in` never depends combinationally on `valid_in`.
- `valid_out` never depends combinationally on `ready_out`.
- `W = 1, C = 1`: four outputs per input.

## Configuration

`UPSAMPLE_PASSTHRU_EN` adds the `scale_1` input.

Defined, with `scale_1 = 1`:
- Combinational passthrough: `ready_in = ready_out`, `valid_out = valid_in`, `data_out = data_in`.
- The state machine holds in LOAD.
- `scale_1` may change only while the state is LOAD with `wr_addr == 0`.

Defined, with `scale_1 = 0`: behaves as the undefined case below.

Undefined:
- The `scale_1` port is absent.
- The block always upsamples.

## Test plan

1. `W=2`, `channels=8`, inputs A,B, `ready_out=1` -> outputs A,A,B,B,A,A,B,B. `valid_out` high T+2..T+9. `ready_in` back high at T+10.
2. `W=1`, `channels=16`, inputs X0,X1 -> outputs X0,X1,X0,X1,X0,X1,X0,X1.
3. `W=3`, `C=2`, random `ready_out` (50%) -> 24-vector sequence matches the model. `data_out` is stable during every stall.
4. Two consecutive rows P,Q with `W=2`, `C=1`, `valid_in` always high -> 8 outputs from P, then Q is accepted only after LOAD resumes, then 8 outputs from Q. No Q data is accepted during P's EMIT.
5. `rst` pulsed after the 3rd output of scenario 1 -> `valid_out=0` the next cycle, `ready_in=1` the cycle after release. A fresh row C,D gives C,C,D,D,C,C,D,D.
6. With `UPSAMPLE_PASSTHRU_EN` and `scale_1=1`, 5 vectors -> same 5 vectors at zero latency. `ready_in` follows `ready_out`.
